serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 90 +++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

   localparam int N_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: a - b - bin, producing the difference bit and the borrow out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial n-bit subtractor: computes x - y LSB first, one bit per clock, with borrow and overflow.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int n = N_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [n-1:0] x,
   input  logic [n-1:0] y,
   output logic [n-1:0] d,
   output logic         bout,
   output logic         overflow,
   output logic         busy,
   output logic         done
);

   localparam int CW = $clog2(n + 1);
   localparam logic [CW-1:0] LAST = CW'(n - 1);

   // Handshake: start is accepted on any rising edge while not busy (IDLE or DONE);
   // busy is high for the n SHIFT cycles, then done pulses for one cycle with d/bout/overflow valid.
   state_t state, state_nxt;

   logic [n-1:0]  xs, ys, rs;
   logic [CW-1:0] cnt;
   logic          borrow;
   logic          fs_diff, fs_bout;

   full_subtractor u_fs (
      .a    (xs[0]),
      .b    (ys[0]),
      .bin  (borrow),
      .diff (fs_diff),
      .bout (fs_bout)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (cnt == LAST) state_nxt = DONE;
         DONE:    state_nxt = start ? SHIFT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == SHIFT);
      done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         xs       <= '0;
         ys       <= '0;
         rs       <= '0;
         cnt      <= '0;
         borrow   <= 1'b0;
         d        <= '0;
         bout     <= 1'b0;
         overflow <= 1'b0;
      end else if (state == SHIFT) begin
         xs     <= xs >> 1;
         ys     <= ys >> 1;
         rs     <= {fs_diff, rs[n-1:1]};
         borrow <= fs_bout;
         cnt    <= cnt + CW'(1);
         // On the last bit xs[0]/ys[0] are the operand sign bits and fs_diff is the result sign.
         if (cnt == LAST) begin
            d        <= {fs_diff, rs[n-1:1]};
            bout     <= fs_bout;
            overflow <= (xs[0] ^ ys[0]) & (fs_diff ^ xs[0]);
         end
      end else if (start) begin
         xs     <= x;
         ys     <= y;
         rs     <= '0;
         cnt    <= '0;
         borrow <= 1'b0;
      end
   end

endmodule
